mem_dbus: RTL and testbench

//  Memory-access stage. Sits between ex_mem and mem_wb and produces the mem_wd/mem_wreg/mem_wdata/llbit fields mem_wb latches.

---
 rtl/mem_dbus_if.sv | 22 ++
 rtl/mem_dbus.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_dbus.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dbus_if.sv
// Data-bus interface between the memory-access stage (master) and the
// data memory / bus fabric (slave). The request fields are held stable by
// the master from request until acknowledge.
interface mem_dbus_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_dbus.sv
// Memory-access pipeline stage. Loads and stores run as a req/ack
// transaction on the data bus while stallreq holds the pipeline; every other
// op passes straight through to mem_wb. Byte lanes are big-endian.
// Optional feature macro: ALIGN_EXC_EN -- misaligned accesses raise an
// address-error exception (excepttype_o[12]) instead of being silently
// aligned.
module mem_dbus (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [7:0]        mem_aluop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_reg2_i,
  input  logic              llbit_i,
  input  logic              stall_mem,
  input  logic              flush,
  mem_dbus_if.master        dbus,
  output logic              stallreq,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              mem_llbit_we,
  output logic              mem_llbit_value,
  output logic [31:0]       excepttype_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t state, state_nxt;

  // Bus request registers and the transaction context kept for DONE.
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;
  logic [7:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  // Decode of the incoming op.
  logic is_load, is_store, is_mem, is_byte, is_half, is_word;
  logic sc_fail, addr_err, start;
  logic [1:0]  off_eff;
  logic [3:0]  sel_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] load_data;
  logic [7:0]  byte_q;
  logic [15:0] half_q;

  assign is_load  = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LBU) ||
                    (mem_aluop_i == OP_LH) || (mem_aluop_i == OP_LHU) ||
                    (mem_aluop_i == OP_LW) || (mem_aluop_i == OP_LL);
  assign is_store = (mem_aluop_i == OP_SB) || (mem_aluop_i == OP_SH) ||
                    (mem_aluop_i == OP_SW) || (mem_aluop_i == OP_SC);
  assign is_mem   = is_load || is_store;
  assign is_byte  = (mem_aluop_i == OP_LB) || (mem_aluop_i == OP_LBU) ||
                    (mem_aluop_i == OP_SB);
  assign is_half  = (mem_aluop_i == OP_LH) || (mem_aluop_i == OP_LHU) ||
                    (mem_aluop_i == OP_SH);
  assign is_word  = is_mem && !is_byte && !is_half;
  // A store-conditional with a cleared link bit never reaches the bus.
  assign sc_fail  = (mem_aluop_i == OP_SC) && !llbit_i;

`ifdef ALIGN_EXC_EN
  // Misaligned accesses trap; aligned ones use the raw lane offset.
  assign addr_err = is_mem && ((is_half && mem_addr_i[0]) ||
                               (is_word && (mem_addr_i[1:0] != 2'b00)));
  assign off_eff  = mem_addr_i[1:0];
`else
  // Misaligned accesses proceed with the offending low bits cleared.
  assign addr_err = 1'b0;
  assign off_eff  = is_word ? 2'b00 :
                    is_half ? {mem_addr_i[1], 1'b0} : mem_addr_i[1:0];
`endif

  assign start = is_mem && !sc_fail && !addr_err && !flush;

  // Byte-lane select and lane-replicated store data for the incoming op.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel_nxt   = 4'b1111;
    wdata_nxt = mem_reg2_i;
    if (is_byte) begin
      sel_nxt   = 4'b1000 >> off_eff;
      wdata_nxt = {4{mem_reg2_i[7:0]}};
    end else if (is_half) begin
      sel_nxt   = off_eff[1] ? 4'b0011 : 4'b1100;
      wdata_nxt = {2{mem_reg2_i[15:0]}};
    end
  end

  // State register.
  // NOTE: asynchronous reset sits in the sensitivity list; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = BUSY;
      BUSY: begin
        if (flush && dbus.dbus_ack) state_nxt = IDLE;
        else if (flush)             state_nxt = ABORT;
        else if (dbus.dbus_ack)     state_nxt = DONE;
      end
      DONE:  if (flush || !stall_mem) state_nxt = IDLE;
      ABORT: if (dbus.dbus_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers and captured transaction context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= '0;
      off_q   <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        req_q   <= 1'b1;
        we_q    <= is_store;
        addr_q  <= {mem_addr_i[31:2], 2'b00};
        sel_q   <= sel_nxt;
        wdata_q <= wdata_nxt;
        op_q    <= mem_aluop_i;
        off_q   <= off_eff;
        wd_q    <= mem_wd_i;
        wreg_q  <= mem_wreg_i;
      end
      if ((state == BUSY || state == ABORT) && dbus.dbus_ack) begin
        req_q <= 1'b0;
        if (state == BUSY) rdata_q <= dbus.dbus_rdata;
      end
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = wdata_q;

  // Lane extraction and sign/zero extension of the captured read data.
  always_comb begin
    case (off_q)
      2'd0:    byte_q = rdata_q[31:24];
      2'd1:    byte_q = rdata_q[23:16];
      2'd2:    byte_q = rdata_q[15:8];
      default: byte_q = rdata_q[7:0];
    endcase
    half_q = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{byte_q[7]}}, byte_q};
      OP_LBU:  load_data = {24'h0, byte_q};
      OP_LH:   load_data = {{16{half_q[15]}}, half_q};
      OP_LHU:  load_data = {16'h0, half_q};
      default: load_data = rdata_q;
    endcase
  end

  // Outputs toward mem_wb and ctrl.
  always_comb begin
    stallreq        = 1'b0;
    mem_wd          = '0;
    mem_wreg        = 1'b0;
    mem_wdata       = '0;
    mem_llbit_we    = 1'b0;
    mem_llbit_value = 1'b0;
    excepttype_o    = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (flush) begin
            // flushed op becomes a NOP
          end else if (addr_err) begin
            excepttype_o[12] = 1'b1;
            mem_wd           = mem_wd_i;
          end else if (sc_fail) begin
            mem_wd   = mem_wd_i;
            mem_wreg = mem_wreg_i;
          end else if (is_mem) begin
            stallreq = 1'b1;
            mem_wd   = mem_wd_i;
          end else begin
            mem_wd    = mem_wd_i;
            mem_wreg  = mem_wreg_i;
            mem_wdata = mem_wdata_i;
          end
        end
        BUSY, ABORT: stallreq = 1'b1;
        DONE: begin
          if (!flush) begin
            mem_wd = wd_q;
            if (op_q == OP_SC) begin
              mem_wdata    = 32'd1;
              mem_wreg     = 1'b1;
              mem_llbit_we = 1'b1;
            end else if (!we_q) begin
              mem_wreg  = wreg_q;
              mem_wdata = load_data;
              if (op_q == OP_LL) begin
                mem_llbit_we    = 1'b1;
                mem_llbit_value = 1'b1;
              end
            end
          end
        end
        default: stallreq = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus.sv
// Directed self-checking bench for mem_dbus: reset, pass-through, every
// load width, stores, LL/SC, flush during a transaction, misaligned access
// and reset in the middle of a transaction.
module tb_mem_dbus;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  mem_wd_i = '0;
  logic        mem_wreg_i = 1'b0;
  logic [31:0] mem_wdata_i = '0;
  logic [7:0]  mem_aluop_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_reg2_i = '0;
  logic        llbit_i = 1'b0;
  logic        stall_mem = 1'b0;
  logic        flush = 1'b0;
  logic        stallreq, mem_wreg, mem_llbit_we, mem_llbit_value;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, excepttype_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_dbus_if bus ();

  mem_dbus dut (
    .clk             (clk),
    .rst             (rst),
    .mem_wd_i        (mem_wd_i),
    .mem_wreg_i      (mem_wreg_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_aluop_i     (mem_aluop_i),
    .mem_addr_i      (mem_addr_i),
    .mem_reg2_i      (mem_reg2_i),
    .llbit_i         (llbit_i),
    .stall_mem       (stall_mem),
    .flush           (flush),
    .dbus            (bus),
    .stallreq        (stallreq),
    .mem_wd          (mem_wd),
    .mem_wreg        (mem_wreg),
    .mem_wdata       (mem_wdata),
    .mem_llbit_we    (mem_llbit_we),
    .mem_llbit_value (mem_llbit_value),
    .excepttype_o    (excepttype_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg);
    mem_aluop_i = op;
    mem_addr_i  = addr;
    mem_reg2_i  = reg2;
    mem_wd_i    = wd;
    mem_wreg_i  = wreg;
  endtask

  // Load with ack on the first BUSY cycle; checks the request fields and the formatted result.
  task automatic run_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_sel, input logic [31:0] exp_data);
    set_op(op, addr, 32'h0, 5'd7, 1'b1);
    #1;
    check({tag, "_stall_idle"}, stallreq, 1);
    check({tag, "_wreg_idle"}, mem_wreg, 0);
    step();
    check({tag, "_req"}, bus.dbus_req, 1);
    check({tag, "_we"}, bus.dbus_we, 0);
    check({tag, "_addr"}, bus.dbus_addr, exp_addr);
    check({tag, "_sel"}, bus.dbus_sel, exp_sel);
    check({tag, "_stall_busy"}, stallreq, 1);
    bus.dbus_ack   = 1'b1;
    bus.dbus_rdata = rdata;
    step();
    bus.dbus_ack   = 1'b0;
    bus.dbus_rdata = '0;
    #1;
    check({tag, "_req_done"}, bus.dbus_req, 0);
    check({tag, "_stall_done"}, stallreq, 0);
    check({tag, "_data"}, mem_wdata, exp_data);
    check({tag, "_wreg_done"}, mem_wreg, 1);
    check({tag, "_wd_done"}, mem_wd, 7);
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
  endtask

  initial begin
    bus.dbus_ack   = 1'b0;
    bus.dbus_rdata = '0;

    // Reset: outputs forced to zero even with live inputs.
    mem_wdata_i = 32'h0000_0055;
    set_op(OP_NOP, 32'h0, 32'h0, 5'd3, 1'b1);
    step();
    check("rst_req", bus.dbus_req, 0);
    check("rst_stall", stallreq, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wreg", mem_wreg, 0);
    rst = 1'b0;
    step();

    // Non-memory pass-through.
    mem_wdata_i = 32'hDEAD_BEEF;
    set_op(OP_NOP, 32'h0, 32'h0, 5'd5, 1'b1);
    #1;
    check("pass_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("pass_wd", mem_wd, 5);
    check("pass_wreg", mem_wreg, 1);
    check("pass_stall", stallreq, 0);
    check("pass_req", bus.dbus_req, 0);
    mem_wdata_i = '0;
    step();

    // Loads of every width and lane.
    run_load("lb",  OP_LB,  32'h0000_1003, 32'h0000_00F0, 32'h0000_1000, 4'b0001, 32'hFFFF_FFF0);
    run_load("lbu", OP_LBU, 32'h0000_1001, 32'h00A5_0000, 32'h0000_1000, 4'b0100, 32'h0000_00A5);
    run_load("lh",  OP_LH,  32'h0000_1002, 32'h0000_8001, 32'h0000_1000, 4'b0011, 32'hFFFF_8001);
    run_load("lhu", OP_LHU, 32'h0000_1000, 32'h8001_7FFF, 32'h0000_1000, 4'b1100, 32'h0000_8001);
    run_load("lw",  OP_LW,  32'h0000_1004, 32'hCAFE_F00D, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D);

    // SH: replicated halfword on the low lanes, no register write.
    set_op(OP_SH, 32'h0000_2002, 32'h1234_ABCD, 5'd9, 1'b0);
    step();
    check("sh_we", bus.dbus_we, 1);
    check("sh_sel", bus.dbus_sel, 4'b0011);
    check("sh_wdata", bus.dbus_wdata, 32'hABCD_ABCD);
    check("sh_addr", bus.dbus_addr, 32'h0000_2000);
    bus.dbus_ack = 1'b1;
    step();
    bus.dbus_ack = 1'b0;
    check("sh_wreg", mem_wreg, 0);
    check("sh_stall", stallreq, 0);
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // LL with ack on the second BUSY cycle, then held in DONE by stall_mem.
    set_op(OP_LL, 32'h0000_4000, 32'h0, 5'd4, 1'b1);
    step();
    step();
    check("ll_req_busy2", bus.dbus_req, 1);
    check("ll_stall_busy2", stallreq, 1);
    bus.dbus_ack   = 1'b1;
    bus.dbus_rdata = 32'h1122_3344;
    step();
    bus.dbus_ack   = 1'b0;
    bus.dbus_rdata = '0;
    stall_mem      = 1'b1;
    check("ll_data", mem_wdata, 32'h1122_3344);
    check("ll_llwe", mem_llbit_we, 1);
    check("ll_llval", mem_llbit_value, 1);
    step();
    check("ll_hold_data", mem_wdata, 32'h1122_3344);
    check("ll_hold_llwe", mem_llbit_we, 1);
    stall_mem = 1'b0;
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    check("ll_idle_llwe", mem_llbit_we, 0);

    // SC with the link bit set: bus write and success result.
    llbit_i = 1'b1;
    set_op(OP_SC, 32'h0000_4000, 32'h0000_0099, 5'd6, 1'b1);
    #1;
    check("sc_stall_idle", stallreq, 1);
    step();
    check("sc_req", bus.dbus_req, 1);
    check("sc_we", bus.dbus_we, 1);
    check("sc_sel", bus.dbus_sel, 4'b1111);
    check("sc_wdata", bus.dbus_wdata, 32'h0000_0099);
    bus.dbus_ack = 1'b1;
    step();
    bus.dbus_ack = 1'b0;
    check("sc_data", mem_wdata, 1);
    check("sc_wreg", mem_wreg, 1);
    check("sc_llwe", mem_llbit_we, 1);
    check("sc_llval", mem_llbit_value, 0);
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // SC with the link bit clear: no bus cycle, result 0.
    llbit_i = 1'b0;
    set_op(OP_SC, 32'h0000_4000, 32'h0000_0099, 5'd6, 1'b1);
    #1;
    check("scf_stall", stallreq, 0);
    check("scf_data", mem_wdata, 0);
    check("scf_wreg", mem_wreg, 1);
    check("scf_wd", mem_wd, 6);
    check("scf_llwe", mem_llbit_we, 0);
    step();
    check("scf_req", bus.dbus_req, 0);
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();

    // Flush on the second BUSY cycle, ack arrives later: request held, data discarded.
    set_op(OP_LW, 32'h0000_5000, 32'h0, 5'd3, 1'b1);
    step();
    check("fl_req_b1", bus.dbus_req, 1);
    step();
    flush = 1'b1;
    #1;
    check("fl_wreg_b2", mem_wreg, 0);
    check("fl_stall_b2", stallreq, 1);
    step();
    flush = 1'b0;
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check("fl_req_ab1", bus.dbus_req, 1);
    check("fl_stall_ab1", stallreq, 1);
    check("fl_wreg_ab1", mem_wreg, 0);
    step();
    check("fl_req_ab2", bus.dbus_req, 1);
    check("fl_wreg_ab2", mem_wreg, 0);
    bus.dbus_ack   = 1'b1;
    bus.dbus_rdata = 32'hFFFF_FFFF;
    step();
    bus.dbus_ack   = 1'b0;
    bus.dbus_rdata = '0;
    #1;
    check("fl_req_idle", bus.dbus_req, 0);
    check("fl_stall_idle", stallreq, 0);
    check("fl_wreg_idle", mem_wreg, 0);
    check("fl_data_idle", mem_wdata, 0);
    step();

    // Misaligned LW.
`ifdef ALIGN_EXC_EN
    set_op(OP_LW, 32'h0000_3001, 32'h0, 5'd2, 1'b1);
    #1;
    check("mis_exc", excepttype_o, 32'h0000_1000);
    check("mis_stall", stallreq, 0);
    check("mis_wreg", mem_wreg, 0);
    step();
    check("mis_req", bus.dbus_req, 0);
    set_op(OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
`else
    set_op(OP_LW, 32'h0000_3001, 32'h0, 5'd2, 1'b1);
    #1;
    check("mis_exc", excepttype_o, 0);
    run_load("mis", OP_LW, 32'h0000_3001, 32'h0BAD_CAFE, 32'h0000_3000, 4'b1111, 32'h0BAD_CAFE);
`endif

    // Reset in the middle of a transaction.
    set_op(OP_LB, 32'h0000_1000, 32'h0, 5'd1, 1'b1);
    step();
    check("rb_req_busy", bus.dbus_req, 1);
    mem_wdata_i = 32'h0000_0077;
    set_op(OP_NOP, 32'h0, 32'h0, 5'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("rb_req_rst", bus.dbus_req, 0);
    check("rb_stall_rst", stallreq, 0);
    check("rb_wdata_rst", mem_wdata, 0);
    step();
    rst = 1'b0;
    #1;
    check("rb_req_after", bus.dbus_req, 0);
    check("rb_stall_after", stallreq, 0);
    check("rb_pass_after", mem_wdata, 32'h0000_0077);
    set_op(OP_LB, 32'h0000_1000, 32'h0, 5'd1, 1'b1);
    #1;
    check("rb_idle_stall", stallreq, 1);
    step();
    check("rb_idle_req", bus.dbus_req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
